// File: rtl/psum_accum_bank.sv
// psum_accum_bank: per-column partial-sum accumulator with a shared drain engine.
// Each lane owns a private buffer fed by a read-modify-write pipeline with
// same-address forwarding. Draining streams every lane in parallel through a
// 2-entry skid buffer, with optional ReLU and clear-on-read.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | accumulate traffic accepted, waiting for drain_start
//   S_FLUSH | drain requested, letting in-flight accumulates retire
//   S_DRAIN | issuing reads 0..count-1 and handing words to the consumer
//   S_DONE  | one-cycle drain_done pulse, then back to S_IDLE
module psum_accum_bank #(
    parameter int NUM_COLS  = 32,
    parameter int PSUM_BW   = 32,
    parameter int ADDR_PSUM = 12,
    parameter int DEPTH     = 2048
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          first_pass,
    input  logic [NUM_COLS-1:0]           in_valid,
    input  logic [ADDR_PSUM*NUM_COLS-1:0] in_addr,
    input  logic [PSUM_BW*NUM_COLS-1:0]   in_data,
    input  logic                          drain_start,
    input  logic [ADDR_PSUM:0]            drain_count,
    input  logic                          relu_en,
    input  logic                          clear_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_PSUM-1:0]          out_addr,
    output logic [PSUM_BW*NUM_COLS-1:0]   out_data,
    output logic                          busy,
    output logic                          drain_done,
    output logic                          overrun
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_PSUM:0]   DEPTH_W = (ADDR_PSUM+1)'(DEPTH);
    localparam logic [ADDR_PSUM:0]   CNT_ONE = (ADDR_PSUM+1)'(1);
    localparam logic [ADDR_PSUM-1:0] ADR_ONE = ADDR_PSUM'(1);
    localparam logic [PSUM_BW-1:0]   SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0]   SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_COLS-1:0]   s1_vld, wb_vld;
    logic                  accept_in, pipe_busy, drain_go;
    logic [ADDR_PSUM:0]    count_eff, rem_issue, rem_acc;
    logic [ADDR_PSUM-1:0]  drain_addr, ent0_addr, ent1_addr;
    logic [IDX_W-1:0]      drain_idx;
    logic                  relu_q, clear_q;
    logic [1:0]            buf_cnt;
    logic                  pop, issue, last_pop;
    logic                  load0_new, load0_from1, load1_new;

    assign accept_in = (state_q == S_IDLE);
    // A write accepted in the same cycle as drain_start still counts as in flight.
    assign pipe_busy = (|in_valid) | (|s1_vld) | (|wb_vld);
    assign drain_go  = (state_q == S_IDLE) && drain_start;
    assign drain_idx = drain_addr[IDX_W-1:0];

    assign pop      = (buf_cnt != 2'd0) && out_ready;
    assign issue    = (state_q == S_DRAIN) && (rem_issue != '0) && ((buf_cnt != 2'd2) || pop);
    assign last_pop = pop && (rem_acc == CNT_ONE);

    assign load0_new   = issue && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop));
    assign load0_from1 = pop && (buf_cnt == 2'd2);
    assign load1_new   = issue && (((buf_cnt == 2'd1) && !pop) || ((buf_cnt == 2'd2) && pop));

    assign out_valid  = (buf_cnt != 2'd0);
    assign out_addr   = ent0_addr;
    assign busy       = (state_q == S_FLUSH) || (state_q == S_DRAIN);
    assign drain_done = (state_q == S_DONE);

    // Clamp the requested drain length into 1..DEPTH so the engine always terminates.
    always_comb begin
        count_eff = drain_count;
        if (drain_count == '0)
            count_eff = CNT_ONE;
        else if (drain_count > DEPTH_W)
            count_eff = DEPTH_W;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (drain_start) state_d = pipe_busy ? S_FLUSH : S_DRAIN;
            S_FLUSH: if (!(|s1_vld) && !(|wb_vld)) state_d = S_DRAIN;
            S_DRAIN: if (last_pop) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Drain counters: issue and accept are tracked by separate down-counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relu_q     <= 1'b0;
            clear_q    <= 1'b0;
            rem_issue  <= '0;
            rem_acc    <= '0;
            drain_addr <= '0;
        end else if (drain_go) begin
            relu_q     <= relu_en;
            clear_q    <= clear_en;
            rem_issue  <= count_eff;
            rem_acc    <= count_eff;
            drain_addr <= '0;
        end else begin
            if (issue) begin
                rem_issue  <= rem_issue - CNT_ONE;
                drain_addr <= drain_addr + ADR_ONE;
            end
            if (pop) rem_acc <= rem_acc - CNT_ONE;
        end
    end

    // Skid buffer occupancy and address entries; entry 0 is always the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_cnt   <= 2'd0;
            ent0_addr <= '0;
            ent1_addr <= '0;
        end else begin
            if (issue && !pop)      buf_cnt <= buf_cnt + 2'd1;
            else if (!issue && pop) buf_cnt <= buf_cnt - 2'd1;
            if (load0_new)        ent0_addr <= drain_addr;
            else if (load0_from1) ent0_addr <= ent1_addr;
            if (load1_new)        ent1_addr <= drain_addr;
        end
    end

    // Sticky flag for accumulate traffic that arrived while not accepting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       overrun <= 1'b0;
        else if ((|in_valid) && !accept_in) overrun <= 1'b1;
    end

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
        logic [PSUM_BW-1:0]   mem [DEPTH];
        logic [ADDR_PSUM-1:0] lane_addr, s1_addr, wb_addr;
        logic [PSUM_BW-1:0]   lane_data, s1_data, wb_res, rd_acc;
        logic [PSUM_BW-1:0]   old_val, new_val, drain_val, ent0_data, ent1_data;
        logic [PSUM_BW:0]     sum_ext;
        logic                 lane_rng, s1_rng, s1_v, s1_first, wb_v;

        assign lane_addr = in_addr[ADDR_PSUM*(i+1)-1 -: ADDR_PSUM];
        assign lane_data = in_data[PSUM_BW*(i+1)-1 -: PSUM_BW];
        assign lane_rng  = ({1'b0, lane_addr} < DEPTH_W);
        assign s1_rng    = ({1'b0, s1_addr} < DEPTH_W);
        // The read for s1 was taken at the edge that wrote wb, so wb must be forwarded.
        assign old_val   = (wb_v && (wb_addr == s1_addr)) ? wb_res : rd_acc;
        assign sum_ext   = {s1_data[PSUM_BW-1], s1_data} + {old_val[PSUM_BW-1], old_val};
        assign drain_val = (relu_q && mem[drain_idx][PSUM_BW-1]) ? '0 : mem[drain_idx];

        // Overwrite on first pass, otherwise saturating add.
        always_comb begin
            new_val = sum_ext[PSUM_BW-1:0];
            if (s1_first)
                new_val = s1_data;
            else if (sum_ext[PSUM_BW] != sum_ext[PSUM_BW-1])
                new_val = sum_ext[PSUM_BW] ? SAT_MIN : SAT_MAX;
        end

        // Lane memory: read-first, accumulate write-back or drain clear.
        always_ff @(posedge clk) begin
            rd_acc <= lane_rng ? mem[lane_addr[IDX_W-1:0]] : '0;
            if (s1_v && s1_rng)
                mem[s1_addr[IDX_W-1:0]] <= new_val;
            else if (issue && clear_q)
                mem[drain_idx] <= '0;
        end

        // Operand stage and write-back tracker for forwarding.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_v     <= 1'b0;
                s1_first <= 1'b0;
                s1_addr  <= '0;
                s1_data  <= '0;
                wb_v     <= 1'b0;
                wb_addr  <= '0;
                wb_res   <= '0;
            end else begin
                s1_v <= in_valid[i] && accept_in;
                if (in_valid[i] && accept_in) begin
                    s1_first <= first_pass;
                    s1_addr  <= lane_addr;
                    s1_data  <= lane_data;
                end
                wb_v <= s1_v && s1_rng;
                if (s1_v) begin
                    wb_addr <= s1_addr;
                    wb_res  <= new_val;
                end
            end
        end

        // Skid buffer data for this lane.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ent0_data <= '0;
                ent1_data <= '0;
            end else begin
                if (load0_new)        ent0_data <= drain_val;
                else if (load0_from1) ent0_data <= ent1_data;
                if (load1_new)        ent1_data <= drain_val;
            end
        end

        assign s1_vld[i] = s1_v;
        assign wb_vld[i] = wb_v;
        assign out_data[PSUM_BW*(i+1)-1 -: PSUM_BW] = ent0_data;
    end
endmodule

// File: tb/tb_psum_accum_bank.sv
// Directed bench for psum_accum_bank on a 4-lane, 16-entry configuration.
module tb_psum_accum_bank;
    localparam int NC = 4;
    localparam int BW = 32;
    localparam int AW = 5;
    localparam int DP = 16;
    localparam int DW = NC * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          first_pass;
    logic [NC-1:0] in_valid;
    logic [AW*NC-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_start;
    logic [AW:0]   drain_count;
    logic          relu_en, clear_en;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy, drain_done, overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] mdl [NC][DP];
    logic [DW-1:0] cap_data [DP];
    logic [AW-1:0] cap_addr [DP];
    int  n_words, n_done;
    bit  pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [BW-1:0] relu_exp [4] = '{32'd0, 32'd3, 32'd0, 32'd8};

    always #5 clk = ~clk;

    psum_accum_bank #(.NUM_COLS(NC), .PSUM_BW(BW), .ADDR_PSUM(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .first_pass(first_pass), .in_valid(in_valid),
        .in_addr(in_addr), .in_data(in_data), .drain_start(drain_start),
        .drain_count(drain_count), .relu_en(relu_en), .clear_en(clear_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .drain_done(drain_done), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int lane, input int addr, input logic [BW-1:0] data, input bit first);
        in_valid = '0;
        in_valid[lane] = 1'b1;
        in_addr[AW*lane +: AW] = addr[AW-1:0];
        in_data[BW*lane +: BW] = data;
        first_pass = first;
        tick();
        in_valid = '0;
    endtask

    function automatic logic [DW-1:0] mdl_word(input int a, input bit relu);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < NC; l++)
            w[BW*l +: BW] = (relu && mdl[l][a][BW-1]) ? '0 : mdl[l][a];
        return w;
    endfunction

    task automatic run_drain(input int cnt, input bit relu, input bit clr, input bit toggle,
                             input bit chk, input bit inject, input string nm);
        int cyc, done_cyc;
        bit stalled;
        logic [DW-1:0] hold_d;
        logic [AW-1:0] hold_a;
        drain_count = cnt[AW:0];
        relu_en     = relu;
        clear_en    = clr;
        out_ready   = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        n_words = 0; n_done = 0; stalled = 0; cyc = 0; done_cyc = -1;
        hold_d = '0; hold_a = '0;
        while (n_done == 0 && cyc < 300) begin
            out_ready = toggle ? pat[cyc % 6] : 1'b1;
            if (inject) begin
                if (cyc == 3) begin
                    in_valid = 4'b1000;
                    in_addr[AW*3 +: AW] = 5'd5;
                    in_data[BW*3 +: BW] = 32'd999;
                    first_pass = 1'b1;
                end else begin
                    in_valid = '0;
                end
            end
            if (cyc == 0) begin
                check({nm, "_busy_lat"}, busy, 1);
                check({nm, "_valid_early"}, out_valid, 0);
            end
            if (cyc == 1) check({nm, "_valid_lat"}, out_valid, 1);
            if (stalled) begin
                check({nm, "_stall_data"}, out_data, hold_d);
                check({nm, "_stall_addr"}, out_addr, hold_a);
            end
            if (drain_done) begin
                n_done++;
                done_cyc = cyc;
                check({nm, "_busy_in_done"}, busy, 0);
                stalled = 0;
            end else if (out_valid && out_ready) begin
                if (n_words < DP) begin
                    cap_addr[n_words] = out_addr;
                    cap_data[n_words] = out_data;
                end
                n_words++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                hold_d  = out_data;
                hold_a  = out_addr;
            end
            tick();
            cyc++;
        end
        in_valid  = '0;
        out_ready = 1'b0;
        if (n_done == 0) check({nm, "_done_timeout"}, 0, 1);
        repeat (3) begin
            if (drain_done) n_done++;
            tick();
        end
        check({nm, "_done_pulses"}, n_done, 1);
        check({nm, "_word_count"}, n_words, cnt);
        if (!toggle) check({nm, "_done_cycle"}, done_cyc, cnt + 1);
        if (chk) begin
            for (int k = 0; k < n_words && k < DP; k++) begin
                check({nm, "_addr"}, cap_addr[k], k);
                check({nm, "_data"}, cap_data[k], mdl_word(k, relu));
            end
        end
        if (clr) begin
            for (int k = 0; k < cnt && k < DP; k++)
                for (int l = 0; l < NC; l++) mdl[l][k] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got, cyc;
        reset = 1'b1; first_pass = 1'b0; in_valid = '0; in_addr = '0; in_data = '0;
        drain_start = 1'b0; drain_count = '0; relu_en = 1'b0; clear_en = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // Zero every lane through a clear-on-read drain.
        run_drain(16, 0, 1, 0, 0, 0, "init");

        // Spaced accumulate on lane 3 addr 5: 10, +7, -2.
        put(3, 5, 32'd10, 1); tick(); tick();
        put(3, 5, 32'd7, 0);  tick(); tick();
        put(3, 5, -32'sd2, 0);
        mdl[3][5] = 32'd15;
        // Back-to-back forwarding on lane 0 addr 9.
        put(0, 9, 32'd100, 1);
        put(0, 9, 32'd1, 0);
        put(0, 9, 32'd1, 0);
        put(0, 9, 32'd1, 0);
        mdl[0][9] = 32'd103;
        // Saturation at both ends on lane 1.
        put(1, 0, 32'h7FFF_FFF0, 1);
        put(1, 1, 32'h8000_0005, 1);
        put(1, 0, 32'h0000_0020, 0);
        put(1, 1, -32'sd16, 0);
        mdl[1][0] = 32'h7FFF_FFFF;
        mdl[1][1] = 32'h8000_0000;
        // Out-of-range write must not alias onto addr 4 nor be forwarded.
        put(2, 20, 32'd77, 1);
        put(2, 4, 32'd5, 0);
        mdl[2][4] = 32'd5;
        repeat (3) tick();
        check("overrun_quiet", overrun, 0);

        run_drain(16, 0, 0, 0, 1, 0, "acc");
        check("lane3_addr5", cap_data[5][BW*3 +: BW], 32'd15);
        check("lane0_addr9", cap_data[9][BW*0 +: BW], 32'd103);
        check("sat_max", cap_data[0][BW*1 +: BW], 32'h7FFF_FFFF);
        check("sat_min", cap_data[1][BW*1 +: BW], 32'h8000_0000);

        // ReLU + clear with a stalling consumer.
        put(2, 0, -32'sd5, 1);
        put(2, 1, 32'd3, 1);
        put(2, 2, 32'd0, 1);
        put(2, 3, 32'd8, 1);
        mdl[2][0] = -32'sd5; mdl[2][1] = 32'd3; mdl[2][2] = 32'd0; mdl[2][3] = 32'd8;
        repeat (3) tick();
        run_drain(4, 1, 1, 1, 1, 0, "relu");
        for (int k = 0; k < 4; k++) check("relu_lane2", cap_data[k][BW*2 +: BW], relu_exp[k]);
        run_drain(4, 0, 0, 0, 1, 0, "zero");
        for (int k = 0; k < 4; k++) check("zero_word", cap_data[k], '0);

        // Accumulate traffic during a drain is dropped and flagged.
        run_drain(16, 0, 0, 0, 1, 1, "ovr");
        check("overrun_set", overrun, 1);
        check("ovr_lane3_addr5", cap_data[5][BW*3 +: BW], 32'd15);

        // Reset in the middle of a drain.
        drain_count = 7'd8; relu_en = 1'b0; clear_en = 1'b0; out_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        got = 0; cyc = 0;
        while (got < 2 && cyc < 20) begin
            if (out_valid && out_ready) got++;
            tick();
            cyc++;
        end
        check("mid_words_seen", got, 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_drain(4, 0, 1, 0, 0, 0, "post");
        run_drain(4, 0, 0, 0, 1, 0, "post2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/psum_accum_bank.md
# psum_accum_bank

Parametrised multi-lane partial-sum accumulator placed between the PE array's psum outputs and the quantisation/AXI write-back path. Each of `NUM_COLS` lanes owns a private `DEPTH`-entry buffer. A two-stage read-modify-write pipeline either overwrites (first IC pass) or saturating-adds incoming psums, with same-address forwarding so back-to-back hits are exact. A drain engine streams all lanes in parallel under valid/ready, with optional ReLU and clear-on-read.

## Interface
- `NUM_COLS`, 32: lane count; one psum memory per PE column.
- `PSUM_BW`, 32: psum width, signed two's complement.
- `ADDR_PSUM`, 12: lane address width.
- `DEPTH`, 2048: entries per lane; must satisfy `DEPTH <= 2**ADDR_PSUM`.

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  async, active-high reset.
- `first_pass`  in  1  sampled with each in_valid; 1 = overwrite, 0 = accumulate.
- `in_valid`  in  NUM_COLS  per-lane psum strobe.
- `in_addr`  in  ADDR_PSUM*NUM_COLS  lane i address at `[ADDR_PSUM*(i+1)-1 -: ADDR_PSUM]`.
- `in_data`  in  PSUM_BW*NUM_COLS  lane i psum at `[PSUM_BW*(i+1)-1 -: PSUM_BW]`.
- `drain_start`  in  1  single-cycle pulse that requests a drain.
- `drain_count`  in  ADDR_PSUM+1  entries to drain per lane (1..DEPTH); sampled with drain_start.
- `relu_en`, `clear_en`  in  1 each  sampled with drain_start.
- `out_valid`  out  1  drain word valid.
- `out_ready`  in  1  consumer accept.
- `out_addr`  out  ADDR_PSUM  address of current drain word.
- `out_data`  out  PSUM_BW*NUM_COLS  all lanes' values at out_addr.
- `busy`  out  1  high from accepted drain_start until drain_done.
- `drain_done`  out  1  one-cycle pulse when the last word is accepted.
- `overrun`  out  1  sticky; set when any in_valid arrives outside IDLE; cleared only by reset.

## Operation
- FSM states: IDLE, FLUSH, DRAIN, DONE.
- IDLE: accumulate traffic is accepted.
  - drain_start with the pipeline empty → DRAIN.
  - drain_start with the pipeline non-empty → FLUSH.
- FLUSH: wait until both stages are empty (at most 2 cycles), then → DRAIN.
- DRAIN: issue reads for addresses 0..drain_count-1; after the last handshake → DONE.
- DONE: pulse drain_done for one cycle, deassert busy, → IDLE.
- drain_start outside IDLE: ignored.
- Accumulate pipeline, per lane, independent across lanes:
  - S0: register valid, addr, data and first_pass; issue memory read of addr.
  - S1: compute `new = first ? data : sat(old + data)`, then write `new` to addr.
- `old` source: the registered S1 result when S0's addr equals the S1 addr and S1 was valid in the previous cycle (forwarding); otherwise the memory read data.
- `sat`: compute in PSUM_BW+1 bits, clamp to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
- in_valid outside IDLE: the word is dropped (no memory write) and `overrun` is set.
- Addresses ≥ DEPTH: write suppressed, read returns 0.
- Drain read path:
  - Reads and writes use read-first semantics.
  - With clear_en=1, each drained address is written 0 in the same cycle it is read.
  - With relu_en=1, negative lane values are output as 0; the stored value is unaffected except by the clear.
- Output buffer: 2-entry skid.
  - A read is issued only when the buffer will have a free slot.
  - Throughput is 1 word/cycle while out_ready=1.
  - Order is strictly ascending address.
- Memory contents are not reset; software issues first_pass or clear_en before relying on them.

## Timing
- Reset values: out_valid=0, out_addr=0, out_data=0, busy=0, drain_done=0, overrun=0; FSM=IDLE; pipeline valids=0; skid buffer empty.
- Accumulate latency: in_valid at cycle t → memory written at the end of cycle t+1.
  - A same-address hit at t+1 is forwarded.
  - A hit at t+2 or later reads memory directly.
- Drain latency: drain_start at t (pipeline empty) → busy=1 at t+1, first out_valid at t+2.
- Drain duration with out_ready held high: drain_count words on consecutive cycles; drain_done one cycle after the last handshake.
- Handshake rules:
  - out_valid, once high, holds out_addr/out_data stable until out_ready.
  - Transfer occurs when out_valid & out_ready are both high at a clock edge.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any in-flight drain is abandoned; memory contents are undefined.

## Test plan
- Lane 3, addr 5: first_pass=1 data 10, then first_pass=0 data 7, then first_pass=0 data -2, spaced 3 cycles apart → drain (count 6) shows lane 3 addr 5 = 15.
- Back-to-back forwarding: lane 0, addr 9, four consecutive cycles (first, +1, +1, +1) starting from 100 → value 103.
- Saturation: addr 0 first=0x7FFFFFF0, then add 0x20 → 0x7FFFFFFF; addr 1 first=0x80000005, then add -16 → 0x80000000.
- Drain count 4, relu_en=1, clear_en=1, lane values {-5, 3, 0, 8}, out_ready toggling 1,0,1,1,0,1… → outputs {0,3,0,8} in address order, data stable while stalled, drain_done once; a second drain returns all zeros.
- in_valid asserted during DRAIN → overrun=1, memory unchanged, drain output unaffected.
- Assert reset mid-drain (after 2 words) → out_valid=0, busy=0 asynchronously; a new drain_start after release completes normally.
